// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the ID-stage operand generator:
//   - opcode / funct encodings of the supported instructions
//   - interlock FSM state encoding
//   - operand source-select encoding
//   - small decode helper
package id_operand_stage_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;

  // Load-use interlock states
  typedef enum logic [0:0] {
    ST_NORMAL    = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  // Operand source selection
  typedef enum logic [2:0] {
    SEL_ZERO  = 3'd0,
    SEL_REG   = 3'd1,
    SEL_LINK  = 3'd2,
    SEL_SIMM  = 3'd3,
    SEL_ZIMM  = 3'd4,
    SEL_HIIMM = 3'd5
  } sel_e;

  // True for the memory-access opcodes (address = rs + sign-extended imm)
  function automatic logic is_mem_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Source-operand forwarding mux for one register read port.
// Ports:
//   idx_i              register index being read
//   reg_data_i         register file read data
//   ex_*_i             EX-stage write port (load results are not yet available)
//   mem_*_i            MEM-stage write port (only usable once data is valid)
//   data_o             resolved operand (EX > MEM > register file)
module id_operand_stage_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0]     reg_data_i,
  input  logic                      ex_we_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
  input  logic                      mem_we_i,
  input  logic                      mem_data_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  output logic [DATA_WIDTH-1:0]     data_o
);

  // Priority forwarding; register 0 is hard-wired and never forwarded
  always_comb begin
    data_o = reg_data_i;
    if (idx_i == '0) begin
      data_o = reg_data_i;
    end else if (ex_we_i && !ex_is_load_i && (ex_waddr_i == idx_i)) begin
      data_o = ex_wdata_i;
    end else if (mem_we_i && mem_data_valid_i && (mem_waddr_i == idx_i)) begin
      data_o = mem_wdata_i;
    end else begin
      data_o = reg_data_i;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand generator with EX/MEM forwarding, a load-use interlock
// that waits for a variable-latency memory result, and a registered ID/EX
// output with stall and flush.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i, addr_i      ID instruction valid / PC
//   op_i, funct_i, imm_i    instruction fields
//   rs_addr_i, rt_addr_i    source register indices
//   reg_data_1_i/2_i        register file reads for rs / rt
//   ex_*_i, mem_*_i         downstream write ports used for forwarding/interlock
//   ex_stall_i, flush_i     downstream hold / kill of the ID/EX register
//   id_stall_o              combinational request to hold IF/ID
//   out_valid_o             registered valid to EX
//   operand_1_o/2_o         registered operands
//   store_data_o            registered store data
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_OFFSET    = 8,
  parameter bit LOGIC_IMM_EN   = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [5:0]                op_i,
  input  logic [5:0]                funct_i,
  input  logic [DATA_WIDTH/2-1:0]   imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
  input  logic [DATA_WIDTH-1:0]     reg_data_1_i,
  input  logic [DATA_WIDTH-1:0]     reg_data_2_i,
  input  logic                      ex_we_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
  input  logic                      mem_we_i,
  input  logic                      mem_data_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  input  logic                      ex_stall_i,
  input  logic                      flush_i,
  output logic                      id_stall_o,
  output logic                      out_valid_o,
  output logic [DATA_WIDTH-1:0]     operand_1_o,
  output logic [DATA_WIDTH-1:0]     operand_2_o,
  output logic [DATA_WIDTH-1:0]     store_data_o
);

  localparam int HALF = DATA_WIDTH / 2;

  sel_e                      sel_1_s, sel_2_s;
  logic                      is_store_s;
  logic                      uses_rs_s, uses_rt_s;
  logic                      rs_hazard_s, rt_hazard_s, hazard_s;
  logic [REG_ADDR_WIDTH-1:0] hazard_idx_s;
  logic                      wait_resolved_s;
  logic [ADDR_WIDTH-1:0]     link_addr_s;
  logic [DATA_WIDTH-1:0]     link_data_s, simm_s, zimm_s, hiimm_s;
  logic [DATA_WIDTH-1:0]     rs_data_s, rt_data_s;
  logic [DATA_WIDTH-1:0]     operand_1_s, operand_2_s, store_data_s;

  state_e                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] wait_idx_q, wait_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     operand_1_q, operand_1_d;
  logic [DATA_WIDTH-1:0]     operand_2_q, operand_2_d;
  logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;

  // Link address wraps in the PC width, then is resized to the datapath
  assign link_addr_s = addr_i + ADDR_WIDTH'(LINK_OFFSET);
  assign link_data_s = DATA_WIDTH'(link_addr_s);
  assign simm_s      = {{HALF{imm_i[HALF-1]}}, imm_i};
  assign zimm_s      = {{HALF{1'b0}}, imm_i};
  assign hiimm_s     = {imm_i, {HALF{1'b0}}};

  // Instruction decode into operand source selects
  always_comb begin
    sel_1_s    = SEL_ZERO;
    sel_2_s    = SEL_ZERO;
    is_store_s = 1'b0;
    case (op_i)
      OP_ADDIU: begin
        sel_1_s = SEL_REG;
        sel_2_s = SEL_SIMM;
      end
      OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: begin
        sel_1_s    = SEL_REG;
        sel_2_s    = SEL_SIMM;
        is_store_s = is_mem_op(op_i) && ((op_i == OP_SB) || (op_i == OP_SW));
      end
      OP_LUI: begin
        sel_1_s = SEL_REG;
        sel_2_s = SEL_HIIMM;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        sel_1_s = SEL_REG;
        if (LOGIC_IMM_EN) begin
          sel_2_s = SEL_ZIMM;
        end else begin
          sel_2_s = SEL_ZERO;
        end
      end
      OP_SPECIAL: begin
        if (funct_i == FUNCT_JALR) begin
          sel_1_s = SEL_LINK;
        end else begin
          sel_1_s = SEL_REG;
        end
        sel_2_s = SEL_REG;
      end
      OP_JAL: begin
        sel_1_s = SEL_LINK;
        sel_2_s = SEL_ZERO;
      end
      default: begin
        sel_1_s    = SEL_ZERO;
        sel_2_s    = SEL_ZERO;
        is_store_s = 1'b0;
      end
    endcase
  end

  // rt is consumed either as operand_2 or as store data
  assign uses_rs_s = (sel_1_s == SEL_REG);
  assign uses_rt_s = (sel_2_s == SEL_REG) || is_store_s;

  id_operand_stage_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs (
    .idx_i            (rs_addr_i),
    .reg_data_i       (reg_data_1_i),
    .ex_we_i          (ex_we_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_waddr_i       (ex_waddr_i),
    .ex_wdata_i       (ex_wdata_i),
    .mem_we_i         (mem_we_i),
    .mem_data_valid_i (mem_data_valid_i),
    .mem_waddr_i      (mem_waddr_i),
    .mem_wdata_i      (mem_wdata_i),
    .data_o           (rs_data_s)
  );

  id_operand_stage_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rt (
    .idx_i            (rt_addr_i),
    .reg_data_i       (reg_data_2_i),
    .ex_we_i          (ex_we_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_waddr_i       (ex_waddr_i),
    .ex_wdata_i       (ex_wdata_i),
    .mem_we_i         (mem_we_i),
    .mem_data_valid_i (mem_data_valid_i),
    .mem_waddr_i      (mem_waddr_i),
    .mem_wdata_i      (mem_wdata_i),
    .data_o           (rt_data_s)
  );

  // Operand muxes driven by the decoded selects
  always_comb begin
    operand_1_s = '0;
    operand_2_s = '0;
    case (sel_1_s)
      SEL_REG:  operand_1_s = rs_data_s;
      SEL_LINK: operand_1_s = link_data_s;
      default:  operand_1_s = '0;
    endcase
    case (sel_2_s)
      SEL_REG:   operand_2_s = rt_data_s;
      SEL_SIMM:  operand_2_s = simm_s;
      SEL_ZIMM:  operand_2_s = zimm_s;
      SEL_HIIMM: operand_2_s = hiimm_s;
      default:   operand_2_s = '0;
    endcase
  end

  assign store_data_s = is_store_s ? rt_data_s : '0;

  // Load-use detection; rs wins when both sources hit the same load
  assign rs_hazard_s  = uses_rs_s && (rs_addr_i != '0) && (ex_waddr_i == rs_addr_i);
  assign rt_hazard_s  = uses_rt_s && (rt_addr_i != '0) && (ex_waddr_i == rt_addr_i);
  assign hazard_s     = in_valid_i && ex_we_i && ex_is_load_i && (rs_hazard_s || rt_hazard_s);
  assign hazard_idx_s = rs_hazard_s ? rs_addr_i : rt_addr_i;

  // The awaited load result arrives on the MEM port; fwd_mux picks it up there
  assign wait_resolved_s = mem_we_i && mem_data_valid_i && (mem_waddr_i == wait_idx_q);

  assign id_stall_o = !flush_i &&
                      (ex_stall_i ||
                       ((state_q == ST_NORMAL) && hazard_s) ||
                       ((state_q == ST_LOAD_WAIT) && !wait_resolved_s));

  // Next-state: flush > ex_stall > bubble (hazard / unresolved wait) > capture
  always_comb begin
    state_d      = state_q;
    wait_idx_d   = wait_idx_q;
    out_valid_d  = out_valid_q;
    operand_1_d  = operand_1_q;
    operand_2_d  = operand_2_q;
    store_data_d = store_data_q;
    if (flush_i) begin
      state_d      = ST_NORMAL;
      out_valid_d  = 1'b0;
      operand_1_d  = '0;
      operand_2_d  = '0;
      store_data_d = '0;
    end else if (ex_stall_i) begin
      // EX cannot accept: everything holds (defaults above)
      state_d = state_q;
    end else if ((state_q == ST_NORMAL) && hazard_s) begin
      state_d      = ST_LOAD_WAIT;
      wait_idx_d   = hazard_idx_s;
      out_valid_d  = 1'b0;
      operand_1_d  = '0;
      operand_2_d  = '0;
      store_data_d = '0;
    end else if ((state_q == ST_LOAD_WAIT) && !wait_resolved_s) begin
      out_valid_d  = 1'b0;
      operand_1_d  = '0;
      operand_2_d  = '0;
      store_data_d = '0;
    end else begin
      state_d      = ST_NORMAL;
      out_valid_d  = in_valid_i;
      operand_1_d  = operand_1_s;
      operand_2_d  = operand_2_s;
      store_data_d = store_data_s;
    end
  end

  // ID/EX pipeline register and interlock state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_NORMAL;
      wait_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      operand_1_q  <= '0;
      operand_2_q  <= '0;
      store_data_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_idx_q   <= wait_idx_d;
      out_valid_q  <= out_valid_d;
      operand_1_q  <= operand_1_d;
      operand_2_q  <= operand_2_d;
      store_data_q <= store_data_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign operand_1_o  = operand_1_q;
  assign operand_2_o  = operand_2_q;
  assign store_data_o = store_data_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: a table of single-cycle
// instruction vectors plus directed load-use, flush, stall, and reset sequences.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] addr;
  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] reg_data_1, reg_data_2;
  logic        ex_we, ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_we, mem_data_valid;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        ex_stall, flush;
  logic        id_stall, out_valid;
  logic [31:0] operand_1, operand_2, store_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .addr_i           (addr),
    .op_i             (op),
    .funct_i          (funct),
    .imm_i            (imm),
    .rs_addr_i        (rs_addr),
    .rt_addr_i        (rt_addr),
    .reg_data_1_i     (reg_data_1),
    .reg_data_2_i     (reg_data_2),
    .ex_we_i          (ex_we),
    .ex_is_load_i     (ex_is_load),
    .ex_waddr_i       (ex_waddr),
    .ex_wdata_i       (ex_wdata),
    .mem_we_i         (mem_we),
    .mem_data_valid_i (mem_data_valid),
    .mem_waddr_i      (mem_waddr),
    .mem_wdata_i      (mem_wdata),
    .ex_stall_i       (ex_stall),
    .flush_i          (flush),
    .id_stall_o       (id_stall),
    .out_valid_o      (out_valid),
    .operand_1_o      (operand_1),
    .operand_2_o      (operand_2),
    .store_data_o     (store_data)
  );

  typedef struct packed {
    logic        iv;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        exwe;
    logic        exld;
    logic [4:0]  exwa;
    logic [31:0] exwd;
    logic        mwe;
    logic        mdv;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic        ev;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] esd;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; addr = 32'h0; op = 6'h3F; funct = 6'h00; imm = 16'h0;
    rs_addr = 5'd0; rt_addr = 5'd0; reg_data_1 = 32'h0; reg_data_2 = 32'h0;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0;
    mem_we = 1'b0; mem_data_valid = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0;
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    in_valid = v.iv; op = v.op; funct = v.funct; imm = v.imm;
    rs_addr = v.rs; rt_addr = v.rt; addr = v.addr;
    reg_data_1 = v.rd1; reg_data_2 = v.rd2;
    ex_we = v.exwe; ex_is_load = v.exld; ex_waddr = v.exwa; ex_wdata = v.exwd;
    mem_we = v.mwe; mem_data_valid = v.mdv; mem_waddr = v.mwa; mem_wdata = v.mwd;
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] esd);
    chk({tag, ".out_valid"},  {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".operand_1"},  operand_1, e1);
    chk({tag, ".operand_2"},  operand_2, e2);
    chk({tag, ".store_data"}, store_data, esd);
  endtask

  initial begin
    //            iv    op     funct  imm       rs    rt    addr          rd1           rd2           exwe  exld  exwa  exwd          mwe   mdv   mwa   mwd           ev    e1            e2            esd
    vecs[0]  = '{1'b1, 6'h09, 6'h00, 16'hFFFF, 5'd3, 5'd0, 32'h0,        32'h10,       32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h10,       32'hFFFFFFFF, 32'h0};
    vecs[1]  = '{1'b1, 6'h00, 6'h21, 16'h0,    5'd4, 5'd5, 32'h0,        32'h1,        32'h2,        1'b1, 1'b0, 5'd4, 32'hAA,       1'b1, 1'b1, 5'd5, 32'hCC,       1'b1, 32'hAA,       32'hCC,       32'h0};
    vecs[2]  = '{1'b1, 6'h00, 6'h21, 16'h0,    5'd4, 5'd5, 32'h0,        32'h1,        32'h2,        1'b1, 1'b0, 5'd4, 32'hAA,       1'b1, 1'b1, 5'd4, 32'hBB,       1'b1, 32'hAA,       32'h2,        32'h0};
    vecs[3]  = '{1'b1, 6'h0F, 6'h00, 16'h1234, 5'd7, 5'd0, 32'h0,        32'h55,       32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h55,       32'h12340000, 32'h0};
    vecs[4]  = '{1'b1, 6'h0D, 6'h00, 16'h8001, 5'd2, 5'd0, 32'h0,        32'hF,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'hF,        32'h00008001, 32'h0};
    vecs[5]  = '{1'b1, 6'h2B, 6'h00, 16'hFFFC, 5'd1, 5'd2, 32'h0,        32'h100,      32'hDEAD,     1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h100,      32'hFFFFFFFC, 32'hDEAD};
    vecs[6]  = '{1'b1, 6'h03, 6'h00, 16'h0,    5'd0, 5'd0, 32'hFFFFFFFC, 32'h9,        32'h9,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h4,        32'h0,        32'h0};
    vecs[7]  = '{1'b1, 6'h00, 6'h09, 16'h0,    5'd3, 5'd6, 32'h1000,     32'h33,       32'h77,       1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h1008,     32'h77,       32'h0};
    vecs[8]  = '{1'b1, 6'h00, 6'h21, 16'h0,    5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 5'd0, 32'h99,       1'b1, 1'b1, 5'd0, 32'h98,       1'b1, 32'h0,        32'h0,        32'h0};
    vecs[9]  = '{1'b1, 6'h00, 6'h21, 16'h0,    5'd6, 5'd0, 32'h0,        32'h11,       32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd6, 32'h22,       1'b1, 32'h11,       32'h0,        32'h0};
    vecs[10] = '{1'b1, 6'h09, 6'h00, 16'h0005, 5'd1, 5'd9, 32'h0,        32'h40,       32'h0,        1'b1, 1'b1, 5'd9, 32'h66,       1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h40,       32'h5,        32'h0};
    vecs[11] = '{1'b1, 6'h02, 6'h00, 16'h1111, 5'd1, 5'd2, 32'h0,        32'h5,        32'h6,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 6'h09, 6'h00, 16'h0002, 5'd3, 5'd0, 32'h0,        32'h21,       32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h21,       32'h2,        32'h0};
    vecs[13] = '{1'b1, 6'h0E, 6'h00, 16'hFFFF, 5'd2, 5'd0, 32'h0,        32'hF0,       32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 32'hF0,       32'h0000FFFF, 32'h0};

    // Reset with a live instruction in ID: outputs must stay zero
    idle();
    rst = 1'b1;
    apply(vecs[0]);
    tick();
    tick();
    chk_outs("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("reset.id_stall", {31'd0, id_stall}, 32'd0);
    rst = 1'b0;
    idle();
    tick();

    // Single-cycle instruction table
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d.id_stall", i), {31'd0, id_stall}, 32'd0);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e1, vecs[i].e2, vecs[i].esd);
    end

    // Load-use: LW r2 in EX, ADDU rs=2 rt=3 in ID, memory slow for 3 cycles
    idle();
    in_valid = 1'b1; op = 6'h00; funct = 6'h21; rs_addr = 5'd2; rt_addr = 5'd3;
    reg_data_1 = 32'hDEAD; reg_data_2 = 32'h5;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hBAD;
    #1;
    chk("lu.detect.id_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("lu.bubble.out_valid", {31'd0, out_valid}, 32'd0);
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h1234; mem_data_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lu.wait%0d.id_stall", c), {31'd0, id_stall}, 32'd1);
      tick();
      chk($sformatf("lu.wait%0d.out_valid", c), {31'd0, out_valid}, 32'd0);
    end
    mem_data_valid = 1'b1;
    #1;
    chk("lu.resolve.id_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk_outs("lu.resolve", 1'b1, 32'h1234, 32'h5, 32'h0);
    idle();
    tick();

    // Flush in LOAD_WAIT: bubble, then back in NORMAL
    in_valid = 1'b1; op = 6'h00; funct = 6'h21; rs_addr = 5'd2; rt_addr = 5'd0;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2;
    tick();
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b1; mem_waddr = 5'd2; mem_data_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush.id_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk_outs("flush", 1'b0, 32'h0, 32'h0, 32'h0);
    flush = 1'b0;
    reg_data_1 = 32'h42;
    #1;
    chk("postflush.id_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk_outs("postflush", 1'b1, 32'h42, 32'h0, 32'h0);
    idle();

    // ex_stall holds the ID/EX register while ID changes
    in_valid = 1'b1; op = 6'h09; rs_addr = 5'd3; reg_data_1 = 32'h10; imm = 16'h0001;
    tick();
    chk_outs("stall.pre", 1'b1, 32'h10, 32'h1, 32'h0);
    ex_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      op = 6'h2B; rs_addr = 5'd1; rt_addr = 5'd2;
      reg_data_1 = 32'h200 + c; reg_data_2 = 32'hBEEF; imm = 16'h0008;
      #1;
      chk($sformatf("stall%0d.id_stall", c), {31'd0, id_stall}, 32'd1);
      tick();
      chk_outs($sformatf("stall%0d", c), 1'b1, 32'h10, 32'h1, 32'h0);
    end
    ex_stall = 1'b0;
    tick();
    chk_outs("stall.release", 1'b1, 32'h201, 32'h8, 32'hBEEF);

    // JAL wrap, then synchronous reset clears everything
    idle();
    apply(vecs[6]);
    tick();
    chk_outs("jal", 1'b1, 32'h4, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    chk_outs("rst2", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the ID-stage operand generator; feeds the EX stage.
- Generates operand_1, operand_2 and store data from the instruction fields and the register file.
- Adds EX/MEM forwarding, a load-use interlock that tolerates variable memory latency, and a registered ID/EX output with stall/flush.
- Optional zero-extended logic-immediate ops.

Parameters:
- DATA_WIDTH, 32, datapath width; imm is DATA_WIDTH/2.
- ADDR_WIDTH, 32, PC width.
- REG_ADDR_WIDTH, 5, register index width.
- LINK_OFFSET, 8, link address = addr + LINK_OFFSET.
- LOGIC_IMM_EN, 1, enables ANDI/ORI/XORI (zero-ext imm in operand_2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ID holds a valid instruction
- addr  in  ADDR_WIDTH  PC of ID instruction
- op  in  6  opcode
- funct  in  6  function field
- imm  in  DATA_WIDTH/2  immediate
- rs_addr, rt_addr  in  REG_ADDR_WIDTH  source indices
- reg_data_1, reg_data_2  in  DATA_WIDTH  register file reads (rs, rt)
- ex_we, ex_is_load  in  1  EX writes a register / EX is a load
- ex_waddr  in  REG_ADDR_WIDTH; ex_wdata  in  DATA_WIDTH
- mem_we, mem_data_valid  in  1  MEM writes / MEM result ready
- mem_waddr  in  REG_ADDR_WIDTH; mem_wdata  in  DATA_WIDTH
- ex_stall  in  1  downstream cannot accept
- flush  in  1  kill ID/EX contents
- id_stall  out  1  upstream must hold IF/ID
- out_valid  out  1  registered valid to EX
- operand_1, operand_2, store_data  out  DATA_WIDTH  registered operands

Behaviour:
- Operand_1 source:
  - ADDIU, LUI, LB, LW, LBU, SB, SW, logic-imm: rs.
  - SPECIAL: JALR gives link_addr, else rs.
  - JAL: link_addr.
  - Others: 0.
- Operand_2 source:
  - LUI: {imm,0}.
  - ADDIU and loads/stores: sign-extended imm.
  - ANDI/ORI/XORI (if LOGIC_IMM_EN): zero-extended imm; otherwise these ops give 0.
  - SPECIAL: rt.
  - Others: 0.
- store_data: rt for SB/SW, else 0.
- "Uses rs" / "uses rt" are derived from the selections above; index 0 never forwards and never hazards.
- Forward priority per source: EX (ex_we & !ex_is_load & match) > MEM (mem_we & mem_data_valid & match) > register file.
- Load-use hazard: in_valid & ex_we & ex_is_load & ex_waddr matches a used nonzero source.
- FSM:
  - NORMAL: hazard & !ex_stall → insert bubble, go to LOAD_WAIT.
  - LOAD_WAIT: leave when mem_we & mem_data_valid & mem_waddr matches the waited register (index latched on entry). Forward mem_wdata, register the output, return to NORMAL. Otherwise stay, bubbling.
- Output register, evaluated each edge in priority order:
  1. rst: operands/store_data 0, out_valid 0, state NORMAL, latched index 0.
  2. flush: out_valid 0, operands 0, state NORMAL (including mid-LOAD_WAIT).
  3. ex_stall: hold all registered outputs and state.
  4. Hazard/wait: out_valid 0 (bubble), operands 0.
  5. Otherwise: capture the generated values, out_valid = in_valid.
- Latency: 1 cycle, ID inputs to registered outputs.
- id_stall (combinational) = !flush & (ex_stall | hazard-in-NORMAL | LOAD_WAIT-unresolved).
- Arithmetic/width rules:
  - link_addr: ADDR_WIDTH add, wraps modulo 2^ADDR_WIDTH.
  - Extensions produce exactly DATA_WIDTH bits.

Decomposition:
- Shared package: opcode/funct constants (existing defines), state encoding (NORMAL, LOAD_WAIT), and the operand-select enums SEL_ZERO, SEL_REG, SEL_LINK, SEL_SIMM, SEL_ZIMM, SEL_HIIMM.
- One sub-module: fwd_mux, instantiated twice (rs, rt). Inputs: index, regfile data, EX/MEM forward ports. Output: resolved data.

Test Plan:
- ADDIU rs=3 (reg=0x10), imm=0xFFFF, no forwarding → next cycle operand_1=0x10, operand_2=0xFFFFFFFF, out_valid=1.
- SPECIAL ADDU rs=4, rt=5, with EX writing r4=0xAA (non-load) and MEM writing r4=0xBB and r5=0xCC → operand_1=0xAA, operand_2=0xCC.
- LW in EX writing r2, then ADDU rs=2 in ID:
  - id_stall=1, out_valid=0 while mem_data_valid is held low for 3 cycles.
  - When it rises with mem_wdata=0x1234: operand_1=0x1234, out_valid=1, id_stall=0.
- Flush asserted during LOAD_WAIT → out_valid=0, state NORMAL next cycle, id_stall=0 that cycle.
- ex_stall held 2 cycles while new ID instruction changes → registered outputs unchanged; id_stall=1.
- JAL at addr=0xFFFFFFFC → operand_1=0x00000004 (wrap), operand_2=0. rst asserted → all outputs 0.
